// File: rtl/snap_intr_pkg.sv
// Shared types and default widths for the SNAP interrupt bridge.
package snap_intr_pkg;

    localparam int DEF_INT_BITS     = 3;
    localparam int DEF_CONTEXT_BITS = 8;
    localparam int DEF_TMO_WIDTH    = 16;
    localparam int DEF_CNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        RETRY    = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/snap_intr_ctrl.sv
// Bridges the level NVDLA interrupt onto the SNAP request/ack handshake,
// re-issuing the request when the host leaves it unacknowledged too long.
//
// state    | meaning
// IDLE     | no request; launch when intr_pending & int_enable
// REQ      | interrupt high, ack timer running
// RETRY    | one-cycle gap before re-issuing an unacked request
// WAIT_CLR | acked; wait for the NVDLA line to drop
module snap_intr_ctrl
    import snap_intr_pkg::*;
#(
    parameter int          INT_BITS     = DEF_INT_BITS,
    parameter int          CONTEXT_BITS = DEF_CONTEXT_BITS,
    parameter int unsigned SRC_ID       = 0,
    parameter int          TMO_WIDTH    = DEF_TMO_WIDTH,
    parameter int          CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    dla_intr_i,
    input  logic                    int_enable,
    input  logic [CONTEXT_BITS-1:0] ctx_i,
    input  logic [TMO_WIDTH-1:0]    timeout_cycles,
    input  logic                    clear_err,
    output logic                    interrupt,
    output logic [INT_BITS-2:0]     interrupt_src,
    output logic [CONTEXT_BITS-1:0] interrupt_ctx,
    input  logic                    interrupt_ack,
    output logic                    intr_pending,
    output logic                    timeout_err,
    output logic [CNT_WIDTH-1:0]    intr_count,
    output logic [CNT_WIDTH-1:0]    retry_count
);

    state_t               state;
    state_t               state_nxt;
    logic [TMO_WIDTH-1:0] timer;
    logic                 timer_clr;
    logic                 launch;
    logic                 ack_hit;
    logic                 tmo_hit;

    assign interrupt_src = SRC_ID[INT_BITS-2:0];

    // Ack is tested before expiry so a same-cycle ack suppresses the retry.
    always_comb begin
        state_nxt = state;
        timer_clr = 1'b0;
        launch    = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (intr_pending && int_enable) begin
                    state_nxt = REQ;
                    timer_clr = 1'b1;
                    launch    = 1'b1;
                end
            end
            REQ: begin
                if (interrupt_ack) begin
                    state_nxt = WAIT_CLR;
                    ack_hit   = 1'b1;
                end else if ((timeout_cycles != '0) &&
                             (timer == timeout_cycles - TMO_WIDTH'(1))) begin
                    state_nxt = RETRY;
                    tmo_hit   = 1'b1;
                end
            end
            RETRY: begin
                state_nxt = REQ;
                timer_clr = 1'b1;
            end
            WAIT_CLR: begin
                if (!intr_pending) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state         <= IDLE;
            interrupt     <= 1'b0;
            intr_pending  <= 1'b0;
            timer         <= '0;
            interrupt_ctx <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state        <= state_nxt;
            interrupt    <= (state_nxt == REQ);
            intr_pending <= dla_intr_i;
            if (timer_clr) begin
                timer <= '0;
            end else if (state == REQ) begin
                timer <= timer + TMO_WIDTH'(1);
            end
            if (launch) begin
                interrupt_ctx <= ctx_i;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end else if (clear_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_intr_cnt (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .inc   (ack_hit),
        .count (intr_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_retry_cnt (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .inc   (tmo_hit),
        .count (retry_count)
    );

endmodule

// File: tb/tb_snap_intr_ctrl.sv
// Directed bench for snap_intr_ctrl; counters built 4 bits wide to reach saturation.
module tb_snap_intr_ctrl;

    localparam int CW = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          dla_intr_i;
    logic          int_enable;
    logic [7:0]    ctx_i;
    logic [15:0]   timeout_cycles;
    logic          clear_err;
    logic          interrupt;
    logic [1:0]    interrupt_src;
    logic [7:0]    interrupt_ctx;
    logic          interrupt_ack;
    logic          intr_pending;
    logic          timeout_err;
    logic [CW-1:0] intr_count;
    logic [CW-1:0] retry_count;

    int checks = 0;
    int errors = 0;

    snap_intr_ctrl #(.CNT_WIDTH(CW)) dut (
        .ap_clk         (ap_clk),
        .ap_rst         (ap_rst),
        .dla_intr_i     (dla_intr_i),
        .int_enable     (int_enable),
        .ctx_i          (ctx_i),
        .timeout_cycles (timeout_cycles),
        .clear_err      (clear_err),
        .interrupt      (interrupt),
        .interrupt_src  (interrupt_src),
        .interrupt_ctx  (interrupt_ctx),
        .interrupt_ack  (interrupt_ack),
        .intr_pending   (intr_pending),
        .timeout_err    (timeout_err),
        .intr_count     (intr_count),
        .retry_count    (retry_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        dla_intr_i     = 1'b0;
        int_enable     = 1'b0;
        interrupt_ack  = 1'b0;
        clear_err      = 1'b0;
        timeout_cycles = '0;
        ctx_i          = '0;
        ap_rst         = 1'b1;
        tick();
        tick();
        ap_rst = 1'b0;
    endtask

    initial begin
        do_reset();
        ap_rst = 1'b1;
        tick();
        chk("rst_interrupt", interrupt, 0);
        chk("rst_ctx", interrupt_ctx, 0);
        chk("rst_pending", intr_pending, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_icnt", intr_count, 0);
        chk("rst_rcnt", retry_count, 0);
        chk("rst_src", interrupt_src, 0);
        ap_rst = 1'b0;

        // basic handshake
        int_enable = 1'b1;
        ctx_i      = 8'h2A;
        dla_intr_i = 1'b1;
        tick();
        chk("hs_pending", intr_pending, 1);
        chk("hs_int_early", interrupt, 0);
        tick();
        chk("hs_int", interrupt, 1);
        chk("hs_ctx", interrupt_ctx, 8'h2A);
        chk("hs_src", interrupt_src, 0);
        ctx_i = 8'h55;
        tick();
        chk("hs_hold", interrupt, 1);
        chk("hs_ctx_hold", interrupt_ctx, 8'h2A);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        chk("hs_ack_drop", interrupt, 0);
        chk("hs_icnt", intr_count, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hs_no_second", interrupt, 0);
        end
        dla_intr_i = 1'b0;
        tick();
        tick();
        chk("hs_idle", interrupt, 0);
        chk("hs_icnt_final", intr_count, 1);

        // timeout and retry
        do_reset();
        timeout_cycles = 16'd4;
        int_enable     = 1'b1;
        dla_intr_i     = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("tmo_pattern", interrupt, (i % 5 == 4) ? 0 : 1);
            if (i == 4) begin
                chk("tmo_err", timeout_err, 1);
                chk("tmo_rcnt1", retry_count, 1);
            end
        end
        chk("tmo_rcnt2", retry_count, 2);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("tmo_clear", timeout_err, 0);
        chk("tmo_reissue", interrupt, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("tmo_gap", interrupt, 0);
        chk("tmo_err_again", timeout_err, 1);
        chk("tmo_rcnt3", retry_count, 3);
        tick();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        chk("tmo_ack", interrupt, 0);
        chk("tmo_icnt", intr_count, 1);
        chk("tmo_rcnt_final", retry_count, 3);

        // ack lands on the expiry cycle
        do_reset();
        timeout_cycles = 16'd3;
        int_enable     = 1'b1;
        dla_intr_i     = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("col_req", interrupt, 1);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        chk("col_int", interrupt, 0);
        chk("col_err", timeout_err, 0);
        chk("col_rcnt", retry_count, 0);
        chk("col_icnt", intr_count, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("col_wait", interrupt, 0);
        end

        // enable gating and line drop while requesting
        do_reset();
        dla_intr_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("en_gated", interrupt, 0);
        end
        chk("en_pending", intr_pending, 1);
        int_enable = 1'b1;
        tick();
        chk("en_launch", interrupt, 1);
        int_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en_held", interrupt, 1);
        end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        chk("en_ack", interrupt, 0);
        chk("en_icnt", intr_count, 1);
        dla_intr_i = 1'b0;
        tick();
        tick();
        int_enable = 1'b1;
        dla_intr_i = 1'b1;
        tick();
        tick();
        chk("drop_req", interrupt, 1);
        dla_intr_i = 1'b0;
        tick();
        tick();
        chk("drop_held", interrupt, 1);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        chk("drop_ack", interrupt, 0);
        chk("drop_icnt", intr_count, 2);
        tick();
        dla_intr_i = 1'b1;
        tick();
        tick();
        chk("drop_relaunch", interrupt, 1);

        // spurious ack and saturation
        do_reset();
        int_enable    = 1'b1;
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        chk("spur_icnt", intr_count, 0);
        chk("spur_int", interrupt, 0);
        for (int i = 0; i < 18; i++) begin
            dla_intr_i = 1'b1;
            tick();
            tick();
            chk("sat_req", interrupt, 1);
            interrupt_ack = 1'b1;
            tick();
            interrupt_ack = 1'b0;
            dla_intr_i    = 1'b0;
            if (i == 0) begin
                interrupt_ack = 1'b1;
                tick();
                interrupt_ack = 1'b0;
                chk("spur_wait_icnt", intr_count, 1);
            end else begin
                tick();
            end
            tick();
            if (i == 14) chk("sat_at_max", intr_count, 4'hF);
        end
        chk("sat_final", intr_count, 4'hF);

        // asynchronous reset mid-request
        do_reset();
        int_enable = 1'b1;
        ctx_i      = 8'hC3;
        dla_intr_i = 1'b1;
        tick();
        tick();
        chk("ar_req", interrupt, 1);
        #3;
        ap_rst = 1'b1;
        #1;
        chk("ar_int", interrupt, 0);
        chk("ar_ctx", interrupt_ctx, 0);
        chk("ar_pending", intr_pending, 0);
        #2;
        ap_rst = 1'b0;
        tick();
        chk("ar_fresh_pending", intr_pending, 1);
        chk("ar_no_req", interrupt, 0);
        tick();
        chk("ar_relaunch", interrupt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
